// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
// Groups the signals between the shift sequencer and everything around it:
//   req0_* / req1_*  : valid/ready request ports of the two requesters
//                      (operand data and shift amount travel with valid)
//   resp_*           : valid/ready result port, tagged with the requester id
//   sh_in/sh_n/sh_out: connection to the shared combinational left shifter
//   busy             : sequencer is shifting or holding a result
// Modport slave is the sequencer's view; master is the surrounding system.
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int AMT_W = 4
);
    logic             req0_valid;
    logic [15:0]      req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_ready;

    logic             req1_valid;
    logic [15:0]      req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_ready;

    logic             resp_valid;
    logic             resp_ready;
    logic [15:0]      resp_data;
    logic             resp_id;

    logic [15:0]      sh_in;
    logic [2:0]       sh_n;
    logic [15:0]      sh_out;

    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_amt,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt,
        output req1_ready,
        output resp_valid, resp_data, resp_id,
        input  resp_ready,
        output sh_in, sh_n,
        input  sh_out,
        output busy
    );

    modport master (
        output req0_valid, req0_data, req0_amt,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt,
        input  req1_ready,
        input  resp_valid, resp_data, resp_id,
        output resp_ready,
        input  sh_in, sh_n,
        output sh_out,
        input  busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Round-robin arbiter plus multi-pass controller for a shared 16-bit
// combinational left shifter that can only shift by 0..7 per pass.
// A granted request (data, amount) is shifted in passes of at most 7 bits,
// then the truncated result is offered on the response port with the id of
// the requester that owns it.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : shift_sequencer_if.slave (requests, response, shifter, busy)
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             grant_any_s;
    logic             grant_id_s;
    logic [15:0]      sel_data_s;
    logic [AMT_W-1:0] sel_amt_s;
    logic [2:0]       step_s;
    logic [AMT_W-1:0] rem_after_s;

    logic             req0_ready_s;
    logic             req1_ready_s;
    logic             resp_valid_s;
    logic [15:0]      resp_data_s;
    logic             resp_id_s;
    logic [15:0]      sh_in_s;
    logic [2:0]       sh_n_s;
    logic             busy_s;

    // Size of the next pass: the remaining amount, capped at the shifter's 7.
    function automatic logic [2:0] pass_step(input logic [AMT_W-1:0] rem);
        logic [2:0] step;
        if (rem > AMT_W'(3'd7)) begin
            step = 3'd7;
        end else begin
            step = rem[2:0];
        end
        return step;
    endfunction

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_any_s = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id_s = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Operand/amount of the granted requester.
    always_comb begin
        if (grant_id_s) begin
            sel_data_s = bus.req1_data;
            sel_amt_s  = bus.req1_amt;
        end else begin
            sel_data_s = bus.req0_data;
            sel_amt_s  = bus.req0_amt;
        end
    end

    // Pass size and remaining amount after the current pass.
    always_comb begin
        step_s      = pass_step(rem_q);
        rem_after_s = rem_q - AMT_W'(step_s);
    end

    // Next-state and output decode of the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        resp_valid_s = 1'b0;
        resp_data_s  = 16'h0000;
        resp_id_s    = 1'b0;
        sh_in_s      = 16'h0000;
        sh_n_s       = 3'd0;
        busy_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready is suppressed while reset is applied so that no
                // requester believes it was accepted in a reset cycle.
                if (!rst && grant_any_s) begin
                    req0_ready_s = ~grant_id_s;
                    req1_ready_s = grant_id_s;
                    acc_d        = sel_data_s;
                    rem_d        = sel_amt_s;
                    id_d         = grant_id_s;
                    last_grant_d = grant_id_s;
                    if (sel_amt_s != {AMT_W{1'b0}}) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The shifter is combinational: its output is captured in the
                // same cycle its inputs are driven.
                busy_s  = 1'b1;
                sh_in_s = acc_q;
                sh_n_s  = step_s;
                acc_d   = bus.sh_out;
                rem_d   = rem_after_s;
                if (rem_after_s == {AMT_W{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                busy_s       = 1'b1;
                resp_valid_s = 1'b1;
                resp_data_s  = acc_q;
                resp_id_s    = id_q;
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so requester 0
    // wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= 16'h0000;
            rem_q        <= {AMT_W{1'b0}};
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = req0_ready_s;
    assign bus.req1_ready = req1_ready_s;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_data  = resp_data_s;
    assign bus.resp_id    = resp_id_s;
    assign bus.sh_in      = sh_in_s;
    assign bus.sh_n       = sh_n_s;
    assign bus.busy       = busy_s;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Self-checking bench: a transaction-level reference (grant rule, list of
// pass sizes, result = data << amt) is compared with the DUT every cycle,
// plus directed scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, v1 = 1'b0, rr = 1'b1;
    logic [15:0] d0 = 16'h0000, d1 = 16'h0000;
    logic [3:0]  a0 = 4'd0, a1 = 4'd0;

    int n_cmp = 0;
    int n_bad = 0;

    shift_sequencer_if #(.AMT_W(4)) bus ();

    assign bus.req0_valid = v0;
    assign bus.req0_data  = d0;
    assign bus.req0_amt   = a0;
    assign bus.req1_valid = v1;
    assign bus.req1_data  = d1;
    assign bus.req1_amt   = a1;
    assign bus.resp_ready = rr;
    // Behaviour of the external combinational shifter.
    assign bus.sh_out     = bus.sh_in << bus.sh_n;

    shift_sequencer #(.AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model state ----------------
    bit          m_busy    = 1'b0;
    bit          m_last    = 1'b1;
    bit          m_id      = 1'b0;
    bit          m_took0   = 1'b0;
    bit          m_took1   = 1'b0;
    logic [15:0] m_res     = 16'h0000;
    logic [15:0] m_data    = 16'h0000;
    int          m_shifted = 0;
    int          passes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shl(input logic [15:0] d, input int k);
        logic [31:0] t;
        t = {16'h0000, d} << k;
        return t[15:0];
    endfunction

    // Per-cycle compare, then advance the reference to the coming edge.
    initial begin : cmp_proc
        bit          g;
        bit          e_r0, e_r1, e_rv, in_shift;
        logic [2:0]  e_shn;
        logic [15:0] e_shin;
        int          amt, rem, s;
        forever begin
            @(negedge clk);
            g        = (v0 && v1) ? !m_last : v1;
            e_r0     = !rst && !m_busy && (v0 || v1) && (g == 1'b0);
            e_r1     = !rst && !m_busy && (v0 || v1) && (g == 1'b1);
            in_shift = m_busy && (passes.size() > 0);
            e_rv     = m_busy && (passes.size() == 0);
            e_shn    = in_shift ? 3'(passes[0]) : 3'd0;
            e_shin   = in_shift ? shl(m_data, m_shifted) : 16'h0000;
            check("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
            check("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
            check("busy",       32'(bus.busy),       32'(m_busy));
            check("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
            check("sh_n",       32'(bus.sh_n),       32'(e_shn));
            check("sh_in",      32'(bus.sh_in),      32'(e_shin));
            if (e_rv) begin
                check("resp_data", 32'(bus.resp_data), 32'(m_res));
                check("resp_id",   32'(bus.resp_id),   32'(m_id));
            end
            m_took0 = 1'b0;
            m_took1 = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
                m_last = 1'b1;
                passes.delete();
            end else if (!m_busy) begin
                if (v0 || v1) begin
                    m_id      = g;
                    m_last    = g;
                    m_data    = g ? d1 : d0;
                    amt       = g ? int'(a1) : int'(a0);
                    m_res     = shl(m_data, amt);
                    m_shifted = 0;
                    rem       = amt;
                    while (rem > 0) begin
                        s = (rem > 7) ? 7 : rem;
                        passes.push_back(s);
                        rem -= s;
                    end
                    m_busy = 1'b1;
                    if (g) m_took1 = 1'b1;
                    else   m_took0 = 1'b1;
                end
            end else if (passes.size() > 0) begin
                m_shifted += passes.pop_front();
            end else if (rr) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [2:0] sn_tr [0:19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && m_busy; k++) tick();
        check("idle_timeout", 32'(m_busy), 32'd0);
    endtask

    // Issue one request from an idle sequencer; check literal result and the
    // cycle distance from the accept cycle to the first resp_valid.
    task automatic do_req(input bit id, input logic [15:0] d, input logic [3:0] a,
                          input logic [15:0] exp, input int lat);
        bit got;
        int n;
        wait_idle();
        rr = 1'b1;
        if (id) begin v1 = 1'b1; d1 = d; a1 = a; end
        else    begin v0 = 1'b1; d0 = d; a0 = a; end
        got = 1'b0;
        n   = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            sn_tr[k] = bus.sh_n;
            if (bus.resp_valid) begin
                got = 1'b1;
                n   = k;
                check("dir_data", 32'(bus.resp_data), 32'(exp));
                check("dir_id",   32'(bus.resp_id),   32'(id));
            end
            tick();
            if (k == 0) begin v0 = 1'b0; v1 = 1'b0; end
        end
        check("dir_got",     32'(got), 32'd1);
        check("dir_latency", 32'(n),   32'(lat));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_proc
        int          cnt;
        bit          got;
        logic        ids [0:3];
        logic [15:0] res [0:3];

        // Reset with a request pending: everything must read zero.
        v0 = 1'b1; d0 = 16'hBEEF; a0 = 4'd3;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data",  32'(bus.resp_data),  32'd0);
        check("rst_resp_id",    32'(bus.resp_id),    32'd0);
        check("rst_sh_in",      32'(bus.sh_in),      32'd0);
        check("rst_sh_n",       32'(bus.sh_n),       32'd0);
        tick();
        v0  = 1'b0;
        rst = 1'b0;

        // Multi-pass, max amount with truncation, zero amount.
        do_req(1'b0, 16'h0001, 4'd10, 16'h0400, 3);
        check("mp_pass1", 32'(sn_tr[1]), 32'd7);
        check("mp_pass2", 32'(sn_tr[2]), 32'd3);
        do_req(1'b1, 16'hFFFF, 4'd15, 16'h8000, 4);
        check("max_pass1", 32'(sn_tr[1]), 32'd7);
        check("max_pass2", 32'(sn_tr[2]), 32'd7);
        check("max_pass3", 32'(sn_tr[3]), 32'd1);
        do_req(1'b0, 16'hA5A5, 4'd0, 16'hA5A5, 1);

        // Round robin right after reset.
        wait_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v0 = 1'b1; d0 = 16'h0003; a0 = 4'd1;
        v1 = 1'b1; d1 = 16'h0005; a1 = 4'd1;
        rr = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60 && cnt < 4; k++) begin
            @(negedge clk);
            check("rr_overlap", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.resp_valid) begin
                ids[cnt] = bus.resp_id;
                res[cnt] = bus.resp_data;
                cnt++;
            end
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        check("rr_count", 32'(cnt), 32'd4);
        if (cnt == 4) begin
            check("rr_id0", 32'(ids[0]), 32'd0);
            check("rr_id1", 32'(ids[1]), 32'd1);
            check("rr_id2", 32'(ids[2]), 32'd0);
            check("rr_id3", 32'(ids[3]), 32'd1);
            check("rr_res0", 32'(res[0]), 32'h0006);
            check("rr_res1", 32'(res[1]), 32'h000A);
            check("rr_res2", 32'(res[2]), 32'h0006);
            check("rr_res3", 32'(res[3]), 32'h000A);
        end
        wait_idle();

        // Backpressure with the other requester waiting.
        rr = 1'b0;
        v1 = 1'b1; d1 = 16'h1234; a1 = 4'd3;
        tick();
        v1 = 1'b0;
        v0 = 1'b1; d0 = 16'h0F0F; a0 = 4'd2;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.resp_valid) got = 1'b1;
            else tick();
        end
        check("bp_got", 32'(got), 32'd1);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            check("bp_valid",       32'(bus.resp_valid), 32'd1);
            check("bp_data",        32'(bus.resp_data),  32'h91A0);
            check("bp_id",          32'(bus.resp_id),    32'd1);
            check("bp_other_ready", 32'(bus.req0_ready), 32'd0);
        end
        tick();
        rr = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 32'(bus.resp_valid), 32'd1);
        tick();
        @(negedge clk);
        check("bp_next_accept", 32'(bus.req0_ready), 32'd1);
        tick();
        v0 = 1'b0;
        wait_idle();

        // Reset in the second SHIFT cycle of an amount-14 request.
        v0 = 1'b1; d0 = 16'h0003; a0 = 4'd14;
        tick();
        v0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",   32'(bus.busy),       32'd0);
        check("mid_rst_valid",  32'(bus.resp_valid), 32'd0);
        check("mid_rst_data",   32'(bus.resp_data),  32'd0);
        check("mid_rst_sh_in",  32'(bus.sh_in),      32'd0);
        check("mid_rst_sh_n",   32'(bus.sh_n),       32'd0);
        check("mid_rst_ready0", 32'(bus.req0_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("mid_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        tick();
        do_req(1'b0, 16'h0007, 4'd2, 16'h001C, 2);

        // Randomized traffic, backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (m_took0) v0 = 1'b0;
            if (m_took1) v1 = 1'b0;
            if (!v0 && $urandom_range(0, 2) == 0) begin
                v0 = 1'b1;
                d0 = 16'($urandom);
                a0 = 4'($urandom_range(0, 15));
            end
            if (!v1 && $urandom_range(0, 2) == 0) begin
                v1 = 1'b1;
                d1 = 16'($urandom);
                a1 = 4'($urandom_range(0, 15));
            end
            rr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        tick();
        rst = 1'b0;
        v0  = 1'b0;
        v1  = 1'b0;
        rr  = 1'b1;
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-pass controller and two-port arbiter for the 16-bit combinational left shifter (`shifter`, `O = in << N`, N in 0..7). It accepts shift requests with amounts 0..15 from two requesters and grants them round-robin. It performs each shift as a sequence of at most-7-bit passes through one shared shifter instance, then returns the result on a valid/ready response port tagged with the requester id. It sits between the processor's execute stage (requester 0) and the address/auxiliary unit (requester 1) and the single shifter datapath.

## Interface
- `AMT_W`, default 4: width of the requested shift amount; legal amounts are 0..15.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_data`  in  16  operand from requester 0.
- `req0_amt`  in  AMT_W  shift amount from requester 0.
- `req0_ready`  out  1  requester 0 request accepted this cycle.
- `req1_valid`, `req1_data`, `req1_amt`, `req1_ready`: same signals for requester 1.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  16  `data << amt`, truncated to 16 bits.
- `resp_id`  out  1  index of the requester that owns the result.
- `sh_in`  out  16  drives the shifter's `in`.
- `sh_n`  out  3  drives the shifter's `N`.
- `sh_out`  in  16  the shifter's `O`.
- `busy`  out  1  high in SHIFT or DONE.

## Operation
- State machine has three states: IDLE, SHIFT, DONE. Internal registers: `acc[15:0]`, `rem[AMT_W-1:0]`, `id`, `last_grant`.
- **IDLE, grant:**
  - If only one `reqX_valid` is high, that requester is granted.
  - If both are high, the requester not equal to `last_grant` is granted.
  - `reqX_ready` is combinational and high only for the granted requester, only in IDLE.
  - On accept: `acc <= reqX_data`, `rem <= reqX_amt`, `id <= X`, `last_grant <= X`.
  - Next state is SHIFT if the amount is nonzero, DONE if the amount is 0.
- **SHIFT:** each cycle
  - `step = min(rem, 7)`, `sh_in = acc`, `sh_n = step`.
  - `acc <= sh_out`, `rem <= rem - step`.
  - When `rem - step == 0`, go to DONE.
  - Pass sequence: amount 10 is passes 7, 3; amount 15 is passes 7, 7, 1.
- **DONE:**
  - `resp_valid = 1`, `resp_data = acc`, `resp_id = id`.
  - `resp_data` and `resp_id` are held stable while `resp_ready` is low.
  - On `resp_valid && resp_ready`, go to IDLE.
  - No new request is accepted in the handshake cycle.
- Outside SHIFT: `sh_in = 0`, `sh_n = 0`.
- Requests are never dropped. A requester whose valid is high while the block is busy waits with `ready` low and must hold its inputs.
- Amounts above 15 cannot occur (AMT_W = 4). For larger AMT_W, any result with amount ≥ 16 is 0. The pass loop gives this naturally.
- **Reset:**
  - State goes to IDLE.
  - `acc`, `rem`, `id` clear to 0; `last_grant` goes to 1, so requester 0 wins the first tie.
  - `resp_valid`, `resp_data`, `resp_id`, `busy`, `req0_ready`, `req1_ready`, `sh_in`, `sh_n` are all 0.
  - Reset asserted mid-SHIFT or mid-DONE abandons the operation; no response is produced.

## Timing
- Accept happens in cycle T, where `ready && valid` is high at the rising edge.
- Pass count P = ceil(amt / 7), which is 0 for amt = 0.
- `resp_valid` first goes high in cycle T+1+P.
  - amt 0: T+1.
  - amt 1..7: T+2.
  - amt 8..14: T+3.
  - amt 15: T+4.
- If the response handshakes in cycle D, the earliest next accept is D+1.
- Back-to-back throughput for amount k with `resp_ready` tied high: one result per P+2 cycles.
- The shifter is purely combinational. `sh_out` is sampled in the same cycle `sh_in`/`sh_n` are driven.

## Test plan
- **Single multi-pass shift:** req0 data 0x0001, amt 10 accepted at T -> `sh_n` = 7 at T+1 and 3 at T+2; `resp_valid` at T+3 with `resp_data` 0x0400, `resp_id` 0.
- **Max amount with truncation:** req1 data 0xFFFF, amt 15 -> passes 7, 7, 1; `resp_data` 0x8000 at T+4, `resp_id` 1.
- **Zero amount:** req0 data 0xA5A5, amt 0 -> no SHIFT cycle; `resp_valid` at T+1 with 0xA5A5.
- **Round-robin after reset:** both valid continuously, each with amt 1 and data 0x0003 (req0) / 0x0005 (req1) -> grant order 0, 1, 0, 1; results 0x0006, 0x000A, 0x0006, 0x000A; the `ready` pulses never overlap.
- **Backpressure:** `resp_ready` held low for 5 cycles in DONE -> `resp_valid` stays high; `resp_data` and `resp_id` stay stable; the other requester's `ready` stays 0; handshake on the 6th cycle, return to IDLE, next accept one cycle later.
- **Reset mid-operation:** `rst` asserted in the second SHIFT cycle of an amt 14 request -> next cycle IDLE, all outputs 0; no `resp_valid` ever appears for that request; a fresh req0 with amt 2 afterwards completes normally at T+2.
